uart_mmio_bridge: RTL and testbench
===================================

// Module: uart_mmio_bridge
// PURPOSE
//  Memory-mapped controller between the single-cycle core's data-memory port and the UART TX/RX engines.
//  Decodes core loads/stores in a 16-byte window; buffers outgoing bytes in a TX FIFO and incoming bytes in an RX FIFO.
//  Sequences the TX engine via valid/ready and exposes status, control and interrupt to firmware.
//  Sits beside data memory; top level muxes RdData using sel.
// PARAMETERS
//  BASE_ADDR  32'h0000_0400  window base; 16-byte aligned
//  TX_DEPTH   8              TX FIFO entries; power of 2, >=2
//  RX_DEPTH   8              RX FIFO entries; power of 2, >=2
// PORTS
//  clk       in   1   single clock, rising edge
//  reset     in   1   asynchronous, active-high
//  Addr      in   32  core data address
//  WriteData in   32  core store data; only [7:0] used except CTRL/STATUS
//  MemWrite  in   2   00 none; 01/10/11 store (byte/half/word; width ignored)
//  MemRead   in   1   core load strobe (high for the load's single cycle)
//  sel       out  1   Addr inside window (combinational)
//  RdData    out  32  read data (combinational); 0 when !sel
//  tx_data   out  8   byte to UART TX engine
//  tx_valid  out  1   TX FIFO non-empty && tx_en
//  tx_ready  in   1   TX engine accepts byte
//  rx_data   in   8   byte from UART RX engine
//  rx_valid  in   1   one-cycle pulse, rx_data valid
//  irq       out  1   level interrupt
// BEHAVIOUR
//  Map (offset from BASE_ADDR; Addr[1:0] ignored):
//   0x0 TXDATA  W: push WriteData[7:0]; read -> 0
//   0x4 RXDATA  R: {24'b0, head byte}, pops on MemRead; 0 and no pop if empty; write ignored
//   0x8 STATUS  R: [0]tx_full [1]tx_empty [2]rx_empty [3]rx_full [4]rx_overrun [5]tx_drop
//               W: write-1-to-clear for bits 4,5 only
//   0xC CTRL    RW [3:0]: [0]tx_en [1]rx_en [2]rx_irq_en [3]tx_irq_en; upper bits read 0
//  Reset (async): both FIFOs empty, pointers 0; CTRL=4'b0011; sticky bits 0.
//   Outputs: tx_valid=0, irq=0, tx_data=0 (FIFO storage need not reset; tx_data gated to 0 when !tx_valid).
//  All state updates on the rising clk edge; reads combinational from current state.
//  A write is visible in STATUS/RdData the next cycle.
//  TX path:
//   - Push on write to TXDATA when !tx_full.
//   - Write when tx_full and no pop that cycle: dropped, tx_drop set.
//   - Write when tx_full with a pop in the same cycle: accepted.
//   - tx_valid registered-state derived: first byte reaches tx_valid one cycle after the store (latency 1).
//   - Pop when tx_valid && tx_ready. tx_data must hold stable while tx_valid && !tx_ready.
//   - Clearing tx_en drops tx_valid next cycle without losing FIFO contents.
//  RX path:
//   - rx_valid && rx_en && !rx_full: push.
//   - rx_valid && rx_full: byte dropped, rx_overrun set, unless the same cycle pops RXDATA, then accepted.
//   - rx_valid && !rx_en: ignored, no flag.
//   - Read of an empty RXDATA concurrent with rx_valid: returns 0; the new byte is pushed.
//  Simultaneous push+pop on one FIFO: count unchanged, FIFO order preserved.
//  Pointers are log2(DEPTH)+1 bits and wrap naturally.
//   full  = MSBs differ, rest equal.
//   empty = pointers equal.
//  irq = (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty); combinational from registers.
//  Access outside window: sel=0, RdData=0, no state change.
//  MemWrite!=0 and MemRead both high: store takes effect, no pop.
//  Reset asserted mid-transfer: FIFOs cleared immediately; tx_valid falls asynchronously.
// STRUCTURE
//  uart_mmio_pkg: register offsets (OFS_TXDATA/RXDATA/STATUS/CTRL), STATUS/CTRL bit indices, CTRL reset value.
//  Sub-module sync_fifo #(WIDTH=8, DEPTH)
//   Ports: clk, reset, push, pop, din, dout(head), full, empty.
//   Pushes when full are dropped unless pop is also high; pops when empty are ignored.
//   Instantiated twice (TX, RX).
//  Bridge itself: address decode, CTRL/sticky registers, read mux, irq.
// TESTING
//  1. Store 0x41,0x42,0x43 to TXDATA, tx_ready=1
//     -> tx_data 41,42,43 on consecutive cycles starting 1 cycle after first store; tx_empty=1 after.
//  2. tx_ready=0, store 9 bytes (DEPTH 8)
//     -> tx_full=1 after 8th, tx_drop=1; write 0x20 to STATUS -> tx_drop=0; drain yields bytes 1..8.
//  3. Pulse rx_valid with 0x5A,0xA5 then read RXDATA twice
//     -> 0x5A, 0xA5; third read returns 0, rx_empty=1.
//  4. Fill RX (8 bytes), pulse rx_valid 0xFF
//     -> rx_overrun=1, 0xFF absent; repeat with simultaneous RXDATA read -> 0xFF accepted, no overrun.
//  5. CTRL=4'b0111, RX empty -> irq=0; one rx_valid -> irq=1 next cycle; read RXDATA -> irq=0.
//  6. Reset asserted with tx_valid=1 and both FIFOs partly full
//     -> tx_valid=0 immediately, STATUS=0x06, CTRL=0x3 after release.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg
//   Shared definitions for the UART MMIO bridge:
//   - register word indices (compared against Addr[3:2])
//   - STATUS and CTRL bit positions
//   - CTRL reset value
//   - helper that packs the STATUS read word
package uart_mmio_pkg;

    // Register word index within the 16-byte window (Addr[3:2]).
    localparam logic [1:0] OFS_TXDATA = 2'd0;  // byte offset 0x0
    localparam logic [1:0] OFS_RXDATA = 2'd1;  // byte offset 0x4
    localparam logic [1:0] OFS_STATUS = 2'd2;  // byte offset 0x8
    localparam logic [1:0] OFS_CTRL   = 2'd3;  // byte offset 0xC

    // STATUS bit positions.
    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_EMPTY   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_RX_OVERRUN = 4;
    localparam int ST_TX_DROP    = 5;

    // CTRL bit positions.
    localparam int CTRL_TX_EN     = 0;
    localparam int CTRL_RX_EN     = 1;
    localparam int CTRL_RX_IRQ_EN = 2;
    localparam int CTRL_TX_IRQ_EN = 3;

    // Both engines enabled, interrupts masked.
    localparam logic [3:0] CTRL_RESET = 4'b0011;

    // Assemble the 32-bit STATUS read word from the individual flags.
    function automatic logic [31:0] pack_status(
        input logic tx_full,
        input logic tx_empty,
        input logic rx_empty,
        input logic rx_full,
        input logic rx_overrun,
        input logic tx_drop
    );
        logic [31:0] s;
        s = 32'd0;
        s[ST_TX_FULL]    = tx_full;
        s[ST_TX_EMPTY]   = tx_empty;
        s[ST_RX_EMPTY]   = rx_empty;
        s[ST_RX_FULL]    = rx_full;
        s[ST_RX_OVERRUN] = rx_overrun;
        s[ST_TX_DROP]    = tx_drop;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with a combinational head output.
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   asynchronous active-high reset (pointers only)
//     push   in   write din; dropped when full unless pop is accepted too
//     pop    in   advance head; ignored when empty
//     din    in   WIDTH-bit write data
//     dout   out  WIDTH-bit head entry (valid only when !empty)
//     full   out  DEPTH entries held
//     empty  out  no entries held
//   Pointers carry one extra wrap bit so full and empty are distinguishable
//   without a separate count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; empty/full come from the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    assign dout = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge
//   Memory-mapped bridge between the core data-memory port and the UART
//   TX/RX engines. Decodes a 16-byte window at BASE_ADDR:
//     0x0 TXDATA (W push), 0x4 RXDATA (R pop), 0x8 STATUS (R, W1C [5:4]),
//     0xC CTRL (RW [3:0]).
//   Ports:
//     clk, reset          clock, asynchronous active-high reset
//     Addr, WriteData     core address / store data
//     MemWrite[1:0]       non-zero = store (width ignored)
//     MemRead             load strobe; pops RXDATA
//     sel, RdData         window hit and read data (combinational)
//     tx_data, tx_valid,  byte stream to TX engine (valid/ready)
//     tx_ready
//     rx_data, rx_valid   byte pulses from RX engine
//     irq                 level interrupt
module uart_mmio_bridge
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic [1:0]  MemWrite,
    input  logic        MemRead,
    output logic        sel,
    output logic [31:0] RdData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        irq
);

    logic [3:0] ctrl_q, ctrl_d;
    logic       rx_overrun_q, rx_overrun_d;
    logic       tx_drop_q, tx_drop_d;

    logic       is_store, is_load;
    logic [1:0] ofs;
    logic       tx_push, tx_pop, rx_push, rx_pop;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0] tx_head, rx_head;
    logic       ctrl_wr, status_wr;

    // Bits of the core bus that this block never looks at.
    logic       unused_bits;
    assign unused_bits = ^{Addr[1:0], WriteData[31:8]};

    assign sel = (Addr[31:4] == BASE_ADDR[31:4]);
    assign ofs = Addr[3:2];

    // A cycle with both strobes is a store: it never pops RXDATA.
    assign is_store = sel && (MemWrite != 2'b00);
    assign is_load  = sel && MemRead && (MemWrite == 2'b00);

    assign ctrl_wr   = is_store && (ofs == OFS_CTRL);
    assign status_wr = is_store && (ofs == OFS_STATUS);

    // TX path: tx_valid depends only on registered state, so a byte stored
    // this cycle is offered to the engine from the next cycle on.
    assign tx_valid = !tx_empty && ctrl_q[CTRL_TX_EN];
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_push  = is_store && (ofs == OFS_TXDATA);
    assign tx_data  = tx_valid ? tx_head : 8'h00;

    // RX path: disabled receiver ignores bytes silently.
    assign rx_push = rx_valid && ctrl_q[CTRL_RX_EN];
    assign rx_pop  = is_load && (ofs == OFS_RXDATA);

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (WriteData[7:0]),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Sticky flags: a new event in the same cycle as a clear wins, so no
    // loss is ever hidden from firmware.
    always_comb begin
        ctrl_d       = ctrl_q;
        rx_overrun_d = rx_overrun_q;
        tx_drop_d    = tx_drop_q;
        if (ctrl_wr) ctrl_d = WriteData[3:0];
        if (status_wr && WriteData[ST_RX_OVERRUN]) rx_overrun_d = 1'b0;
        if (status_wr && WriteData[ST_TX_DROP])    tx_drop_d    = 1'b0;
        // rx_full implies non-empty, so rx_pop alone means a slot is freed.
        if (rx_push && rx_full && !rx_pop) rx_overrun_d = 1'b1;
        if (tx_push && tx_full && !tx_pop) tx_drop_d    = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q       <= CTRL_RESET;
            rx_overrun_q <= 1'b0;
            tx_drop_q    <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            rx_overrun_q <= rx_overrun_d;
            tx_drop_q    <= tx_drop_d;
        end
    end

    always_comb begin
        RdData = 32'd0;
        if (sel) begin
            case (ofs)
                OFS_RXDATA: RdData = rx_empty ? 32'd0 : {24'd0, rx_head};
                OFS_STATUS: RdData = pack_status(tx_full, tx_empty, rx_empty,
                                                 rx_full, rx_overrun_q, tx_drop_q);
                OFS_CTRL:   RdData = {28'd0, ctrl_q};
                default:    RdData = 32'd0;
            endcase
        end
    end

    assign irq = (ctrl_q[CTRL_RX_IRQ_EN] && !rx_empty) ||
                 (ctrl_q[CTRL_TX_IRQ_EN] && tx_empty);

endmodule

// File: tb/tb_uart_mmio_bridge.sv
module tb_uart_mmio_bridge;

    localparam logic [31:0] BASE = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic [1:0]  MemWrite = 2'b00;
    logic        MemRead = 1'b0;
    logic        sel;
    logic [31:0] RdData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    uart_mmio_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .Addr      (Addr),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .sel       (sel),
        .RdData    (RdData),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // TX scoreboard: every accepted handshake must match the oldest expected byte.
    always @(negedge clk) begin
        if (reset === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            vectors++;
            if (tx_exp.size() == 0) begin
                miscompares++;
                $display("FAIL tx_unexpected: got %02h expected none", tx_data);
            end else begin
                logic [7:0] e;
                e = tx_exp.pop_front();
                if (tx_data !== e) begin
                    miscompares++;
                    $display("FAIL tx_byte: got %02h expected %02h", tx_data, e);
                end else
                    $display("tx byte %02h", tx_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] ofs, input logic [31:0] d);
        Addr = BASE + ofs; WriteData = d; MemWrite = 2'b11;
        @(posedge clk); #1;
        MemWrite = 2'b00;
    endtask

    task automatic load(input logic [31:0] ofs, output logic [31:0] d);
        Addr = BASE + ofs; MemRead = 1'b1;
        #1 d = RdData;
        @(posedge clk); #1;
        MemRead = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (tx_valid !== 1'b0 || irq !== 1'b0 || tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b irq=%b d=%02h expected 0/0/00", tx_valid, irq, tx_data);
        end
        reset = 1'b0;
        tick();
        load(32'h8, d);
        vectors++;
        if (d !== 32'h06) begin miscompares++; $display("FAIL reset_status: got %0h expected 6", d); end
        load(32'hC, d);
        vectors++;
        if (d !== 32'h03) begin miscompares++; $display("FAIL reset_ctrl: got %0h expected 3", d); end
        $display("reset checked");
    endtask

    task automatic test_tx_basic();
        logic [31:0] d;
        tx_ready = 1'b1;
        tx_exp.push_back(8'h41); tx_exp.push_back(8'h42); tx_exp.push_back(8'h43);
        store(32'h0, 32'h41);
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
            miscompares++;
            $display("FAIL tx_latency: got v=%b d=%02h expected 1/41", tx_valid, tx_data);
        end
        store(32'h0, 32'h42);
        store(32'h0, 32'h43);
        tick();
        vectors++;
        if (tx_exp.size() != 0) begin
            miscompares++;
            $display("FAIL tx_drain1: got %0d left expected 0", tx_exp.size());
        end
        load(32'h8, d);
        vectors++;
        if (d !== 32'h06) begin miscompares++; $display("FAIL tx_empty_after: got %0h expected 6", d); end
    endtask

    task automatic test_tx_full_drop();
        logic [31:0] d;
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            store(32'h0, i);
            if (i <= 8) tx_exp.push_back(i[7:0]);
            if (i == 8) begin
                load(32'h8, d);
                vectors++;
                if (d !== 32'h05) begin miscompares++; $display("FAIL tx_full: got %0h expected 5", d); end
            end
        end
        load(32'h8, d);
        vectors++;
        if (d !== 32'h25) begin miscompares++; $display("FAIL tx_drop: got %0h expected 25", d); end
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
            miscompares++;
            $display("FAIL tx_hold: got v=%b d=%02h expected 1/01", tx_valid, tx_data);
        end
        store(32'h8, 32'h20);
        load(32'h8, d);
        vectors++;
        if (d !== 32'h05) begin miscompares++; $display("FAIL tx_drop_clear: got %0h expected 5", d); end
        tx_ready = 1'b1;
        for (int k = 0; k < 40 && tx_exp.size() > 0; k++) tick();
        vectors++;
        if (tx_exp.size() != 0) begin
            miscompares++;
            $display("FAIL tx_drain2: got %0d left expected 0", tx_exp.size());
        end
        load(32'h8, d);
        vectors++;
        if (d !== 32'h06) begin miscompares++; $display("FAIL tx_drained_status: got %0h expected 6", d); end
    endtask

    task automatic rx_read_check(input string name);
        logic [31:0] d;
        logic [31:0] e;
        e = (rx_exp.size() > 0) ? {24'd0, rx_exp.pop_front()} : 32'd0;
        load(32'h4, d);
        vectors++;
        if (d !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, d, e);
        end else
            $display("rx read %s %02h", name, d[7:0]);
    endtask

    task automatic test_rx_basic();
        logic [31:0] d;
        rx_pulse(8'h5A); rx_exp.push_back(8'h5A);
        rx_pulse(8'hA5); rx_exp.push_back(8'hA5);
        rx_read_check("rx_first");
        rx_read_check("rx_second");
        rx_read_check("rx_empty_read");
        load(32'h8, d);
        vectors++;
        if (d !== 32'h06) begin miscompares++; $display("FAIL rx_empty_status: got %0h expected 6", d); end
        // Read of empty RXDATA concurrent with an arriving byte.
        rx_data = 8'h77; rx_valid = 1'b1;
        rx_read_check("rx_empty_concurrent");
        rx_valid = 1'b0;
        rx_exp.push_back(8'h77);
        rx_read_check("rx_after_concurrent");
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            rx_pulse(8'h10 + i[7:0]);
            rx_exp.push_back(8'h10 + i[7:0]);
        end
        load(32'h8, d);
        vectors++;
        if (d !== 32'h0A) begin miscompares++; $display("FAIL rx_full: got %0h expected a", d); end
        rx_pulse(8'hFF);
        load(32'h8, d);
        vectors++;
        if (d !== 32'h1A) begin miscompares++; $display("FAIL rx_overrun: got %0h expected 1a", d); end
        store(32'h8, 32'h10);
        // Full FIFO, byte arrives while RXDATA is popped: accepted.
        rx_data = 8'hFF; rx_valid = 1'b1;
        rx_read_check("rx_pop_with_push");
        rx_valid = 1'b0;
        rx_exp.push_back(8'hFF);
        load(32'h8, d);
        vectors++;
        if (d !== 32'h0A) begin miscompares++; $display("FAIL rx_no_overrun: got %0h expected a", d); end
        for (int i = 0; i < 8; i++) rx_read_check("rx_drain");
        load(32'h8, d);
        vectors++;
        if (d !== 32'h06) begin miscompares++; $display("FAIL rx_drained: got %0h expected 6", d); end
    endtask

    task automatic test_ctrl_irq();
        logic [31:0] d;
        store(32'hC, 32'h7);
        load(32'hC, d);
        vectors++;
        if (d !== 32'h7) begin miscompares++; $display("FAIL ctrl_rw: got %0h expected 7", d); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_idle: got %b expected 0", irq); end
        rx_pulse(8'h33); rx_exp.push_back(8'h33);
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_rx: got %b expected 1", irq); end
        rx_read_check("irq_read");
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear: got %b expected 0", irq); end
        // Receiver disabled: byte ignored, no overrun.
        store(32'hC, 32'h5);
        rx_pulse(8'h44);
        load(32'h8, d);
        vectors++;
        if (d !== 32'h06) begin miscompares++; $display("FAIL rx_disabled: got %0h expected 6", d); end
        store(32'hC, 32'hB);
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_tx: got %b expected 1", irq); end
        // Out-of-window store must not reach CTRL.
        Addr = BASE + 32'h1C; WriteData = 32'h0; MemWrite = 2'b11;
        #1;
        vectors++;
        if (sel !== 1'b0 || RdData !== 32'd0) begin
            miscompares++;
            $display("FAIL out_of_window: got sel=%b rd=%0h expected 0/0", sel, RdData);
        end
        tick();
        MemWrite = 2'b00;
        // Addr[1:0] ignored: 0xE aliases CTRL.
        load(32'hE, d);
        vectors++;
        if (d !== 32'hB) begin miscompares++; $display("FAIL ctrl_alias: got %0h expected b", d); end
        // Store and load together on RXDATA: no pop.
        rx_pulse(8'h55); rx_exp.push_back(8'h55);
        Addr = BASE + 32'h4; WriteData = 32'h0; MemWrite = 2'b11; MemRead = 1'b1;
        tick();
        MemWrite = 2'b00; MemRead = 1'b0;
        rx_read_check("store_load_no_pop");
        store(32'hC, 32'h3);
    endtask

    task automatic test_reset_midflight();
        logic [31:0] d;
        tx_ready = 1'b0;
        store(32'h0, 32'hA1); store(32'h0, 32'hA2); store(32'h0, 32'hA3);
        tx_exp.push_back(8'hA1); tx_exp.push_back(8'hA2); tx_exp.push_back(8'hA3);
        rx_pulse(8'h61); rx_pulse(8'h62);
        rx_exp.push_back(8'h61); rx_exp.push_back(8'h62);
        store(32'hC, 32'h2);
        vectors++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL tx_en_off: got v=%b d=%02h expected 0/00", tx_valid, tx_data);
        end
        store(32'hC, 32'h3);
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA1) begin
            miscompares++;
            $display("FAIL tx_en_on: got v=%b d=%02h expected 1/a1", tx_valid, tx_data);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b d=%02h irq=%b expected 0/00/0", tx_valid, tx_data, irq);
        end
        tx_exp.delete(); rx_exp.delete();
        tick(); tick();
        reset = 1'b0;
        tx_ready = 1'b1;
        load(32'h8, d);
        vectors++;
        if (d !== 32'h06) begin miscompares++; $display("FAIL post_reset_status: got %0h expected 6", d); end
        load(32'hC, d);
        vectors++;
        if (d !== 32'h03) begin miscompares++; $display("FAIL post_reset_ctrl: got %0h expected 3", d); end
        rx_read_check("post_reset_rx");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_full_drop();
        test_rx_basic();
        test_rx_overrun();
        test_ctrl_irq();
        test_reset_midflight();
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
